// File: rtl/dog_stack.sv
// Difference-of-Gaussian stack: realigns NUM_SCALES skewed convolution streams in
// per-scale FIFOs and emits shifted, saturated scale differences with pixel tags.
module dog_stack #(
    parameter int NUM_SCALES   = 4,
    parameter int RESULT_WIDTH = 24,
    parameter int DIFF_WIDTH   = 14,
    parameter int DIFF_SHIFT   = 10,
    parameter int ALIGN_DEPTH  = 8,
    parameter int IMAGE_COLUMN = 512,
    parameter int IMAGE_ROW    = 512
) (
    input  logic                                     axi_clk,
    input  logic                                     axi_rst,
    input  logic [NUM_SCALES-1:0]                    conv_valid,
    input  logic [NUM_SCALES*RESULT_WIDTH-1:0]       conv_result,
    output logic                                     dog_valid,
    input  logic                                     dog_ready,
    output logic [(NUM_SCALES-1)*DIFF_WIDTH-1:0]     dog_diff,
    output logic [NUM_SCALES-2:0]                    dog_sat,
    output logic [$clog2(IMAGE_COLUMN)-1:0]          dog_col,
    output logic [$clog2(IMAGE_ROW)-1:0]             dog_row,
    output logic                                     dog_sof,
    output logic                                     dog_eol,
    output logic                                     dog_eof,
    input  logic                                     err_clr,
    output logic [NUM_SCALES-1:0]                    ovf_err
);

    localparam int NUM_LANES = NUM_SCALES - 1;
    localparam int PTR_W     = $clog2(ALIGN_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int SUB_W     = RESULT_WIDTH + 1;
    localparam int COL_W     = $clog2(IMAGE_COLUMN);
    localparam int ROW_W     = $clog2(IMAGE_ROW);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_COLUMN - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_ROW - 1);
    localparam logic signed [SUB_W-1:0] SAT_MAX = SUB_W'(2 ** (DIFF_WIDTH - 1) - 1);
    localparam logic signed [SUB_W-1:0] SAT_MIN = ~SAT_MAX;

    logic                              pop;
    logic [NUM_SCALES-1:0]             fifo_nonempty;
    logic [NUM_SCALES-1:0]             fifo_full;
    logic [NUM_SCALES-1:0]             ovf_set;
    logic [RESULT_WIDTH-1:0]           fifo_head [NUM_SCALES];
    logic [NUM_LANES*DIFF_WIDTH-1:0]   diff_calc;
    logic [NUM_LANES-1:0]              sat_calc;

    logic                              dog_valid_q, dog_valid_d;
    logic [NUM_LANES*DIFF_WIDTH-1:0]   dog_diff_q, dog_diff_d;
    logic [NUM_LANES-1:0]              dog_sat_q, dog_sat_d;
    logic [COL_W-1:0]                  dog_col_q, dog_col_d;
    logic [ROW_W-1:0]                  dog_row_q, dog_row_d;
    logic                              dog_sof_q, dog_sof_d;
    logic                              dog_eol_q, dog_eol_d;
    logic                              dog_eof_q, dog_eof_d;
    logic [COL_W-1:0]                  col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]                  row_cnt_q, row_cnt_d;
    logic [NUM_SCALES-1:0]             ovf_err_q, ovf_err_d;

    // All scales advance in lockstep; a sample leaves only once every scale has one.
    assign pop = (&fifo_nonempty) && (!dog_valid_q || dog_ready);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SCALES; gi++) begin : g_fifo
            logic [RESULT_WIDTH-1:0] mem [ALIGN_DEPTH];
            logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0]        count_q, count_d;
            logic                    wr_en;

            assign fifo_full[gi]     = (count_q == CNT_W'(ALIGN_DEPTH));
            assign fifo_nonempty[gi] = (count_q != '0);
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            assign wr_en             = conv_valid[gi] && (!fifo_full[gi] || pop);
            assign ovf_set[gi]       = conv_valid[gi] && fifo_full[gi] && !pop;
            assign fifo_head[gi]     = mem[rd_ptr_q];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                case ({wr_en, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end

            always_ff @(posedge axi_clk or posedge axi_rst) begin
                if (axi_rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            always_ff @(posedge axi_clk) begin
                if (wr_en) begin
                    mem[wr_ptr_q] <= conv_result[gi*RESULT_WIDTH +: RESULT_WIDTH];
                end
            end
        end

        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic signed [SUB_W-1:0] delta;
            logic signed [SUB_W-1:0] shifted;
            logic                    over_hi;
            logic                    over_lo;
            logic [DIFF_WIDTH-1:0]   lane_diff;

            // Operands are unsigned, so one extra bit holds any difference exactly.
            assign delta   = $signed({1'b0, fifo_head[gi+1]}) - $signed({1'b0, fifo_head[gi]});
            assign shifted = delta >>> DIFF_SHIFT;
            assign over_hi = (shifted > SAT_MAX);
            assign over_lo = (shifted < SAT_MIN);

            always_comb begin
                lane_diff = shifted[DIFF_WIDTH-1:0];
                if (over_hi) begin
                    lane_diff = SAT_MAX[DIFF_WIDTH-1:0];
                end else if (over_lo) begin
                    lane_diff = SAT_MIN[DIFF_WIDTH-1:0];
                end
            end

            assign diff_calc[gi*DIFF_WIDTH +: DIFF_WIDTH] = lane_diff;
            assign sat_calc[gi] = over_hi || over_lo;
        end
    endgenerate

    always_comb begin
        dog_valid_d = dog_valid_q;
        dog_diff_d  = dog_diff_q;
        dog_sat_d   = dog_sat_q;
        dog_col_d   = dog_col_q;
        dog_row_d   = dog_row_q;
        dog_sof_d   = dog_sof_q;
        dog_eol_d   = dog_eol_q;
        dog_eof_d   = dog_eof_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;

        if (pop) begin
            dog_valid_d = 1'b1;
            dog_diff_d  = diff_calc;
            dog_sat_d   = sat_calc;
            dog_col_d   = col_cnt_q;
            dog_row_d   = row_cnt_q;
            dog_sof_d   = (col_cnt_q == '0) && (row_cnt_q == '0);
            dog_eol_d   = (col_cnt_q == LAST_COL);
            dog_eof_d   = (col_cnt_q == LAST_COL) && (row_cnt_q == LAST_ROW);
            if (col_cnt_q == LAST_COL) begin
                col_cnt_d = '0;
                row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end else if (dog_ready) begin
            dog_valid_d = 1'b0;
        end

        // A new overflow in the clearing cycle must not be lost.
        ovf_err_d = (ovf_err_q & ~{NUM_SCALES{err_clr}}) | ovf_set;
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            dog_valid_q <= 1'b0;
            dog_diff_q  <= '0;
            dog_sat_q   <= '0;
            dog_col_q   <= '0;
            dog_row_q   <= '0;
            dog_sof_q   <= 1'b0;
            dog_eol_q   <= 1'b0;
            dog_eof_q   <= 1'b0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            ovf_err_q   <= '0;
        end else begin
            dog_valid_q <= dog_valid_d;
            dog_diff_q  <= dog_diff_d;
            dog_sat_q   <= dog_sat_d;
            dog_col_q   <= dog_col_d;
            dog_row_q   <= dog_row_d;
            dog_sof_q   <= dog_sof_d;
            dog_eol_q   <= dog_eol_d;
            dog_eof_q   <= dog_eof_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign dog_valid = dog_valid_q;
    assign dog_diff  = dog_diff_q;
    assign dog_sat   = dog_sat_q;
    assign dog_col   = dog_col_q;
    assign dog_row   = dog_row_q;
    assign dog_sof   = dog_sof_q;
    assign dog_eol   = dog_eol_q;
    assign dog_eof   = dog_eof_q;
    assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_dog_stack.sv
// Scoreboard bench for dog_stack on a 4x2 frame: expected samples are queued as the
// last scale of each pixel is written and compared as the output handshakes.
`timescale 1ns/1ps
module tb_dog_stack;

    localparam int NS   = 4;
    localparam int RW   = 24;
    localparam int DW   = 14;
    localparam int DS   = 10;
    localparam int AD   = 8;
    localparam int IC   = 4;
    localparam int IR   = 2;
    localparam int NL   = NS - 1;
    localparam int CW   = $clog2(IC);
    localparam int ROWW = $clog2(IR);

    logic               axi_clk = 1'b0;
    logic               axi_rst = 1'b1;
    logic [NS-1:0]      conv_valid = '0;
    logic [NS*RW-1:0]   conv_result = '0;
    logic               dog_valid;
    logic               dog_ready = 1'b0;
    logic [NL*DW-1:0]   dog_diff;
    logic [NL-1:0]      dog_sat;
    logic [CW-1:0]      dog_col;
    logic [ROWW-1:0]    dog_row;
    logic               dog_sof, dog_eol, dog_eof;
    logic               err_clr = 1'b0;
    logic [NS-1:0]      ovf_err;

    dog_stack #(
        .NUM_SCALES(NS), .RESULT_WIDTH(RW), .DIFF_WIDTH(DW), .DIFF_SHIFT(DS),
        .ALIGN_DEPTH(AD), .IMAGE_COLUMN(IC), .IMAGE_ROW(IR)
    ) dut (
        .axi_clk(axi_clk), .axi_rst(axi_rst),
        .conv_valid(conv_valid), .conv_result(conv_result),
        .dog_valid(dog_valid), .dog_ready(dog_ready),
        .dog_diff(dog_diff), .dog_sat(dog_sat),
        .dog_col(dog_col), .dog_row(dog_row),
        .dog_sof(dog_sof), .dog_eol(dog_eol), .dog_eof(dog_eof),
        .err_clr(err_clr), .ovf_err(ovf_err)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [NL*DW-1:0] diff;
        logic [NL-1:0]    sat;
        logic [CW-1:0]    col;
        logic [ROWW-1:0]  row;
        logic             sof;
        logic             eol;
        logic             eof;
    } samp_t;

    samp_t          sb[$];
    samp_t          obs[$];
    logic [RW-1:0]  stim [NS][64];
    int             total = 0;
    int             bad = 0;
    int             exp_col = 0;
    int             exp_row = 0;

    // Reference: exact integer difference, floor division, then clamp.
    function automatic samp_t model_sample(input int i);
        samp_t  s;
        longint d;
        longint q;
        longint div;
        div = longint'(1) << DS;
        for (int j = 0; j < NL; j++) begin
            d = longint'(stim[j+1][i]) - longint'(stim[j][i]);
            if (d >= 0) q = d / div;
            else        q = -((-d + div - 1) / div);
            s.sat[j] = 1'b0;
            if (q > 8191)  begin q = 8191;  s.sat[j] = 1'b1; end
            if (q < -8192) begin q = -8192; s.sat[j] = 1'b1; end
            s.diff[j*DW +: DW] = q[DW-1:0];
        end
        s.col = exp_col[CW-1:0];
        s.row = exp_row[ROWW-1:0];
        s.sof = (exp_col == 0) && (exp_row == 0);
        s.eol = (exp_col == IC - 1);
        s.eof = (exp_col == IC - 1) && (exp_row == IR - 1);
        if (exp_col == IC - 1) begin
            exp_col = 0;
            exp_row = (exp_row == IR - 1) ? 0 : exp_row + 1;
        end else begin
            exp_col = exp_col + 1;
        end
        return s;
    endfunction

    task automatic apply_reset();
        conv_valid = '0;
        conv_result = '0;
        dog_ready = 1'b0;
        err_clr = 1'b0;
        @(negedge axi_clk);
        axi_rst = 1'b1;
        @(negedge axi_clk);
        @(negedge axi_clk);
        axi_rst = 1'b0;
        exp_col = 0;
        exp_row = 0;
        sb.delete();
        obs.delete();
    endtask

    task automatic fill_random(input int n);
        logic [RW-1:0] base;
        for (int i = 0; i < n; i++) begin
            base = RW'($urandom_range(0, 4194303));
            for (int k = 0; k < NS; k++) begin
                if (i % 2 == 0) stim[k][i] = RW'($urandom_range(0, 16777215));
                else            stim[k][i] = base + RW'($urandom_range(0, 200000));
            end
        end
    endtask

    // Streams n pixels (scale 3 delayed by skew3), optional ready stall, scoreboard checks.
    task automatic run_stream(input string name, input int n, input int skew3,
                              input int stall_at, input int stall_len,
                              output int first_valid, output int first_wr, output int iters);
        int          seen;
        int          idx;
        bit          held;
        logic [NL*DW-1:0] h_diff;
        logic [NL-1:0]    h_sat;
        logic [5:0]       h_tag;
        samp_t       e;
        samp_t       o;
        seen = 0;
        held = 0;
        h_diff = '0;
        h_sat = '0;
        h_tag = '0;
        first_valid = -1;
        first_wr = skew3;
        iters = 0;
        for (int it = 0; it < n + skew3 + stall_len + 40; it++) begin
            iters = it;
            if (seen == n) break;
            dog_ready = !(it >= stall_at && it < stall_at + stall_len);
            if (dog_valid === 1'b1 && first_valid < 0) first_valid = it;
            if (held) begin
                total++;
                if (dog_valid !== 1'b1 || dog_diff !== h_diff || dog_sat !== h_sat ||
                    {dog_col, dog_row, dog_sof, dog_eol, dog_eof} !== h_tag) begin
                    bad++;
                    $display("FAIL %s hold: valid=%b diff=%h sat=%b got, held diff=%h sat=%b required",
                             name, dog_valid, dog_diff, dog_sat, h_diff, h_sat);
                end
            end
            held = (dog_valid === 1'b1) && !dog_ready;
            h_diff = dog_diff;
            h_sat = dog_sat;
            h_tag = {dog_col, dog_row, dog_sof, dog_eol, dog_eof};
            if (dog_valid === 1'b1 && dog_ready) begin
                o.diff = dog_diff; o.sat = dog_sat; o.col = dog_col; o.row = dog_row;
                o.sof = dog_sof; o.eol = dog_eol; o.eof = dog_eof;
                obs.push_back(o);
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra: got sample %0d with empty scoreboard", name, seen);
                end else begin
                    e = sb.pop_front();
                    if (dog_diff !== e.diff || dog_sat !== e.sat) begin
                        bad++;
                        $display("FAIL %s data[%0d]: got diff=%h sat=%b want diff=%h sat=%b",
                                 name, seen, dog_diff, dog_sat, e.diff, e.sat);
                    end
                    total++;
                    if ({dog_col, dog_row, dog_sof, dog_eol, dog_eof} !==
                        {e.col, e.row, e.sof, e.eol, e.eof}) begin
                        bad++;
                        $display("FAIL %s tag[%0d]: got col=%0d row=%0d sof=%b eol=%b eof=%b want col=%0d row=%0d sof=%b eol=%b eof=%b",
                                 name, seen, dog_col, dog_row, dog_sof, dog_eol, dog_eof,
                                 e.col, e.row, e.sof, e.eol, e.eof);
                    end
                end
                seen++;
            end
            conv_valid = '0;
            for (int k = 0; k < NS; k++) begin
                idx = it - ((k == NS - 1) ? skew3 : 0);
                if (idx >= 0 && idx < n) begin
                    conv_valid[k] = 1'b1;
                    conv_result[k*RW +: RW] = stim[k][idx];
                end
            end
            if (it - skew3 >= 0 && it - skew3 < n) sb.push_back(model_sample(it - skew3));
            @(posedge axi_clk);
            @(negedge axi_clk);
        end
        conv_valid = '0;
        dog_ready = 1'b0;
        total++;
        if (seen != n) begin
            bad++;
            $display("FAIL %s count: got %0d samples want %0d", name, seen, n);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (dog_valid !== 1'b0) begin bad++; $display("FAIL reset valid: got %b want 0", dog_valid); end
        total++;
        if (dog_diff !== '0) begin bad++; $display("FAIL reset diff: got %h want 0", dog_diff); end
        total++;
        if (dog_sat !== '0) begin bad++; $display("FAIL reset sat: got %b want 0", dog_sat); end
        total++;
        if ({dog_col, dog_row, dog_sof, dog_eol, dog_eof} !== '0) begin
            bad++; $display("FAIL reset tags: got %b want 0", {dog_col, dog_row, dog_sof, dog_eol, dog_eof});
        end
        total++;
        if (ovf_err !== '0) begin bad++; $display("FAIL reset ovf: got %b want 0", ovf_err); end
    endtask

    task automatic test_aligned();
        int fv, fw, its;
        logic [NL*DW-1:0] want;
        apply_reset();
        stim[0][0] = 24'd1000; stim[1][0] = 24'd3048; stim[2][0] = 24'd7168; stim[3][0] = 24'd7168;
        want = {14'd0, 14'd4, 14'd2};
        run_stream("aligned", 1, 0, 999, 0, fv, fw, its);
        total++;
        if (fv != fw + 2) begin bad++; $display("FAIL aligned latency: got cycle %0d want %0d", fv, fw + 2); end
        total++;
        if (obs.size() != 1) begin
            bad++; $display("FAIL aligned obs: got %0d samples want 1", obs.size());
        end else if (obs[0].diff !== want || obs[0].sof !== 1'b1 || obs[0].col !== '0 || obs[0].row !== '0) begin
            bad++; $display("FAIL aligned value: got diff=%h sof=%b want diff=%h sof=1", obs[0].diff, obs[0].sof, want);
        end
    endtask

    task automatic test_back_to_back();
        int fv, fw, its;
        apply_reset();
        fill_random(16);
        run_stream("b2b", 16, 0, 6, 5, fv, fw, its);
        total++;
        if (its > 16 + 2 + 5) begin bad++; $display("FAIL b2b throughput: got %0d cycles want <= %0d", its, 23); end
    endtask

    task automatic test_skew();
        int fv, fw, its;
        apply_reset();
        fill_random(20);
        run_stream("skew", 20, 5, 999, 0, fv, fw, its);
        total++;
        if (fv != 7) begin bad++; $display("FAIL skew latency: got cycle %0d want 7", fv); end
        total++;
        if (ovf_err !== '0) begin bad++; $display("FAIL skew ovf: got %b want 0", ovf_err); end
    endtask

    task automatic test_saturation();
        int fv, fw, its;
        logic [DW-1:0] want_l0 [3];
        logic          want_s  [3];
        want_l0[0] = 14'h1FFF; want_l0[1] = 14'h2000; want_l0[2] = 14'h3FFF;
        want_s[0] = 1'b1; want_s[1] = 1'b1; want_s[2] = 1'b0;
        apply_reset();
        fill_random(3);
        stim[0][0] = 24'd0;        stim[1][0] = 24'hFFFFFF;
        stim[0][1] = 24'hFFFFFF;   stim[1][1] = 24'd0;
        stim[0][2] = 24'd5;        stim[1][2] = 24'd4;
        run_stream("sat", 3, 0, 999, 0, fv, fw, its);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs.size() <= i) begin
                bad++; $display("FAIL sat lane0[%0d]: missing sample", i);
            end else if (obs[i].diff[DW-1:0] !== want_l0[i] || obs[i].sat[0] !== want_s[i]) begin
                bad++; $display("FAIL sat lane0[%0d]: got %h sat=%b want %h sat=%b",
                                i, obs[i].diff[DW-1:0], obs[i].sat[0], want_l0[i], want_s[i]);
            end
        end
    endtask

    task automatic test_frame_wrap();
        int fv, fw, its;
        logic w_sof, w_eol, w_eof;
        apply_reset();
        fill_random(9);
        run_stream("frame", 9, 0, 999, 0, fv, fw, its);
        for (int i = 0; i < 9; i++) begin
            w_eol = (i == 3) || (i == 7);
            w_eof = (i == 7);
            w_sof = (i == 0) || (i == 8);
            total++;
            if (obs.size() <= i) begin
                bad++; $display("FAIL frame flags[%0d]: missing sample", i);
            end else if ({obs[i].sof, obs[i].eol, obs[i].eof} !== {w_sof, w_eol, w_eof}) begin
                bad++; $display("FAIL frame flags[%0d]: got sof/eol/eof=%b%b%b want %b%b%b", i,
                                obs[i].sof, obs[i].eol, obs[i].eof, w_sof, w_eol, w_eof);
            end
        end
        total++;
        if (obs.size() < 9) begin
            bad++; $display("FAIL frame wrap tag: missing sample 9");
        end else if (obs[8].col !== '0 || obs[8].row !== '0) begin
            bad++; $display("FAIL frame wrap tag: got (%0d,%0d) want (0,0)", obs[8].col, obs[8].row);
        end
    endtask

    task automatic test_backpressure();
        logic [NL*DW-1:0] snap;
        apply_reset();
        snap = '0;
        dog_ready = 1'b0;
        for (int it = 0; it < 10; it++) begin
            conv_valid = '1;
            for (int k = 0; k < NS; k++) conv_result[k*RW +: RW] = RW'((it + 1) * (k + 1) * 4096);
            @(posedge axi_clk);
            @(negedge axi_clk);
            if (it == 1) begin
                snap = dog_diff;
                total++;
                if (dog_valid !== 1'b1 || dog_diff !== {3{14'd4}}) begin
                    bad++; $display("FAIL bp first: got valid=%b diff=%h want 1 %h", dog_valid, dog_diff, {3{14'd4}});
                end
            end else if (it > 1) begin
                total++;
                if (dog_valid !== 1'b1 || dog_diff !== snap) begin
                    bad++; $display("FAIL bp hold[%0d]: got valid=%b diff=%h want 1 %h", it, dog_valid, dog_diff, snap);
                end
            end
            if (it == 8) begin
                total++;
                if (ovf_err !== 4'b0000) begin bad++; $display("FAIL bp ovf early: got %b want 0000", ovf_err); end
            end
            if (it == 9) begin
                total++;
                if (ovf_err !== 4'b1111) begin bad++; $display("FAIL bp ovf set: got %b want 1111", ovf_err); end
            end
        end
        // Full FIFOs with a pop and a write together: legal, and err_clr clears.
        err_clr = 1'b1;
        dog_ready = 1'b1;
        for (int k = 0; k < NS; k++) conv_result[k*RW +: RW] = RW'(11 * (k + 1) * 4096);
        @(posedge axi_clk);
        @(negedge axi_clk);
        total++;
        if (ovf_err !== 4'b0000) begin bad++; $display("FAIL bp clear: got %b want 0000", ovf_err); end
        total++;
        if (dog_valid !== 1'b1 || dog_diff !== {3{14'd8}}) begin
            bad++; $display("FAIL bp next: got valid=%b diff=%h want 1 %h", dog_valid, dog_diff, {3{14'd8}});
        end
        dog_ready = 1'b0;
        @(posedge axi_clk);
        @(negedge axi_clk);
        total++;
        if (ovf_err !== 4'b1111) begin bad++; $display("FAIL bp set wins: got %b want 1111", ovf_err); end
        conv_valid = '0;
        @(posedge axi_clk);
        @(negedge axi_clk);
        err_clr = 1'b0;
        total++;
        if (ovf_err !== 4'b0000) begin bad++; $display("FAIL bp clear2: got %b want 0000", ovf_err); end
    endtask

    task automatic test_midframe_reset();
        int fv, fw, its;
        bit stale;
        apply_reset();
        fill_random(5);
        dog_ready = 1'b1;
        for (int it = 0; it < 5; it++) begin
            conv_valid = '1;
            for (int k = 0; k < NS; k++) conv_result[k*RW +: RW] = stim[k][it];
            @(posedge axi_clk);
            @(negedge axi_clk);
        end
        conv_valid = '0;
        dog_ready = 1'b0;
        #2;
        axi_rst = 1'b1;
        #1;
        total++;
        if (dog_valid !== 1'b0 || dog_diff !== '0 || dog_sat !== '0) begin
            bad++; $display("FAIL midrst outputs: got valid=%b diff=%h sat=%b want 0", dog_valid, dog_diff, dog_sat);
        end
        total++;
        if ({dog_col, dog_row, dog_sof, dog_eol, dog_eof} !== '0 || ovf_err !== '0) begin
            bad++; $display("FAIL midrst tags: got %b ovf=%b want 0",
                            {dog_col, dog_row, dog_sof, dog_eol, dog_eof}, ovf_err);
        end
        @(negedge axi_clk);
        axi_rst = 1'b0;
        exp_col = 0;
        exp_row = 0;
        sb.delete();
        obs.delete();
        dog_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge axi_clk);
            @(negedge axi_clk);
            if (dog_valid !== 1'b0) stale = 1;
        end
        total++;
        if (stale) begin bad++; $display("FAIL midrst stale: got dog_valid=1 want 0"); end
        fill_random(1);
        run_stream("midrst", 1, 0, 999, 0, fv, fw, its);
        total++;
        if (obs.size() != 1 || obs[0].sof !== 1'b1) begin
            bad++; $display("FAIL midrst sof: got %0d samples, first sof not set, want 1 sample sof=1", obs.size());
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_back_to_back();
        test_skew();
        test_saturation();
        test_frame_wrap();
        test_backpressure();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
